// File: rtl/sprite_access_scheduler_if.sv
// Command channel from the instruction processor into the sprite access
// scheduler: valid/ready handshake plus the command fields.
interface sprite_access_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_selector;
  logic [5:0] cmd_level;
  logic [5:0] cmd_id;
  logic [5:0] cmd_in01;
  logic [5:0] cmd_in02;
  logic [9:0] cmd_col;
  logic [9:0] cmd_row;

  // Requester side: offers commands, observes ready.
  modport master (
    output cmd_valid, cmd_selector, cmd_level, cmd_id, cmd_in01, cmd_in02,
           cmd_col, cmd_row,
    input  cmd_ready
  );

  // Scheduler side: accepts commands, drives ready.
  modport slave (
    input  cmd_valid, cmd_selector, cmd_level, cmd_id, cmd_in01, cmd_in02,
           cmd_col, cmd_row,
    output cmd_ready
  );
endinterface

// File: rtl/sprite_access_scheduler.sv
// Sprite access scheduler: arbitrates the sprite position finder between
// per-pixel lookups and buffered function commands. One access is in flight
// at a time; start pulses and all results are registered outputs.
module sprite_access_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int FUNC_WAIT   = 4,
  parameter int PIX_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_req,
  input  logic [9:0]                    H_in,
  input  logic [9:0]                    V_in,
  output logic                          pix_ack,
  output logic                          pix_overrun,
  sprite_access_scheduler_if.slave      cmd,
  output logic                          active_finder_position,
  output logic [9:0]                    H_pos_out,
  output logic [9:0]                    V_pos_out,
  output logic                          active_function_processor,
  output logic [1:0]                    function_selector,
  output logic [5:0]                    function_level_sprit,
  output logic [5:0]                    function_id_sprit,
  output logic [5:0]                    function_input01,
  output logic [5:0]                    function_input02,
  output logic [9:0]                    function_col,
  output logic [9:0]                    function_row,
  input  logic                          active_high_four,
  input  logic                          function_sp_colision_out,
  output logic                          colision_valid,
  output logic                          colision_hit,
  output logic                          timeout_err,
  output logic                          bad_cmd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (PIX_TIMEOUT > FUNC_WAIT) ? PIX_TIMEOUT : FUNC_WAIT;
  localparam int TW   = $clog2(TMAX) + 1;

  typedef struct packed {
    logic [1:0] sel;
    logic [5:0] level;
    logic [5:0] id;
    logic [5:0] in01;
    logic [5:0] in02;
    logic [9:0] col;
    logic [9:0] row;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, PIX_ISSUE, PIX_WAIT, CMD_ISSUE, CMD_WAIT} state_t;

  state_t          state_reg, state_next;
  cmd_t            fifo_mem [FIFO_DEPTH];
  cmd_t            head, incoming;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            cmd_ready_reg;
  logic            push, pop, fifo_full, fifo_empty;
  logic            pend_reg;
  logic [9:0]      pend_h_reg, pend_v_reg;
  logic [TW-1:0]   timer_reg;
  logic            hit_latch_reg;

  assign cmd.cmd_ready = cmd_ready_reg;
  assign fifo_count    = count_reg;
  assign incoming      = '{cmd.cmd_selector, cmd.cmd_level, cmd.cmd_id, cmd.cmd_in01,
                           cmd.cmd_in02, cmd.cmd_col, cmd.cmd_row};
  assign head          = fifo_mem[rd_ptr_reg];
  assign push          = cmd.cmd_valid & cmd_ready_reg;
  assign pop           = (state_reg == CMD_ISSUE);
  assign fifo_full     = (count_reg == CW'(FIFO_DEPTH));
  assign fifo_empty    = (count_reg == '0);

  // Occupancy after this cycle's push/pop; also feeds the registered ready.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Command storage; contents need no reset since count/pointers qualify them.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= incoming;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state: pixels win unless the FIFO is full, then one command goes first.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pend_reg && !fifo_full) state_next = PIX_ISSUE;
        else if (!fifo_empty)       state_next = CMD_ISSUE;
      end
      PIX_ISSUE: state_next = PIX_WAIT;
      PIX_WAIT: begin
        if (active_high_four || timer_reg == TW'(PIX_TIMEOUT - 1)) state_next = IDLE;
      end
      CMD_ISSUE: state_next = (function_selector == 2'b11) ? IDLE : CMD_WAIT;
      CMD_WAIT: begin
        if (timer_reg == TW'(FUNC_WAIT - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: pending pixel, FIFO pointers, start pulses, results and sticky flags.
  // Start pulses and their fields are loaded on entry to the issue states so
  // they appear in the issue cycle itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg                <= '0;
      rd_ptr_reg                <= '0;
      count_reg                 <= '0;
      cmd_ready_reg             <= 1'b1;
      pend_reg                  <= 1'b0;
      pend_h_reg                <= '0;
      pend_v_reg                <= '0;
      timer_reg                 <= '0;
      hit_latch_reg             <= 1'b0;
      pix_ack                   <= 1'b0;
      pix_overrun               <= 1'b0;
      active_finder_position    <= 1'b0;
      H_pos_out                 <= '0;
      V_pos_out                 <= '0;
      active_function_processor <= 1'b0;
      function_selector         <= '0;
      function_level_sprit      <= '0;
      function_id_sprit         <= '0;
      function_input01          <= '0;
      function_input02          <= '0;
      function_col              <= '0;
      function_row              <= '0;
      colision_valid            <= 1'b0;
      colision_hit              <= 1'b0;
      timeout_err               <= 1'b0;
      bad_cmd                   <= 1'b0;
    end else begin
      // FIFO bookkeeping; power-of-two depth lets the pointers wrap naturally.
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg     <= count_next;
      cmd_ready_reg <= (count_next < CW'(FIFO_DEPTH));

      // A request in the issue cycle becomes the next pending one, not an overrun.
      if (pix_req) begin
        pend_reg   <= 1'b1;
        pend_h_reg <= H_in;
        pend_v_reg <= V_in;
        if (pend_reg && state_reg != PIX_ISSUE) pix_overrun <= 1'b1;
      end else if (state_reg == PIX_ISSUE) begin
        pend_reg <= 1'b0;
      end

      // Issue the newest coordinates, including an overwrite arriving this cycle.
      active_finder_position <= (state_next == PIX_ISSUE);
      if (state_next == PIX_ISSUE) begin
        H_pos_out <= pix_req ? H_in : pend_h_reg;
        V_pos_out <= pix_req ? V_in : pend_v_reg;
      end
      pix_ack <= (state_reg == PIX_WAIT) && active_high_four;
      if (state_reg == PIX_WAIT && !active_high_four && timer_reg == TW'(PIX_TIMEOUT - 1))
        timeout_err <= 1'b1;

      // Shared wait timer, restarted by either issue state.
      if (state_reg == PIX_ISSUE || state_reg == CMD_ISSUE)
        timer_reg <= '0;
      else if (state_reg == PIX_WAIT || state_reg == CMD_WAIT)
        timer_reg <= timer_reg + 1'b1;

      // Function command fields are latched from the FIFO head on entry.
      active_function_processor <= (state_next == CMD_ISSUE) && (head.sel != 2'b11);
      if (state_next == CMD_ISSUE) begin
        function_selector    <= head.sel;
        function_level_sprit <= head.level;
        function_id_sprit    <= head.id;
        function_input01     <= head.in01;
        function_input02     <= head.in02;
        function_col         <= head.col;
        function_row         <= head.row;
      end
      if (state_reg == CMD_ISSUE && function_selector == 2'b11) bad_cmd <= 1'b1;

      // Collision result is registered so its pulse lands in the last wait cycle.
      if (state_reg == CMD_ISSUE)
        hit_latch_reg <= 1'b0;
      else if (state_reg == CMD_WAIT && function_selector == 2'b10 && function_sp_colision_out)
        hit_latch_reg <= 1'b1;
      colision_valid <= (state_reg == CMD_WAIT) && (function_selector == 2'b10) &&
                        (timer_reg == TW'(FUNC_WAIT - 2));
      if (state_reg == CMD_WAIT && function_selector == 2'b10 && timer_reg == TW'(FUNC_WAIT - 2))
        colision_hit <= hit_latch_reg | function_sp_colision_out;
    end
  end

endmodule

// File: tb/tb_sprite_access_scheduler.sv
// Directed bench for sprite_access_scheduler. Each loop iteration is one
// cycle: inputs for cycle t are driven and outputs of cycle t are checked
// 1 time unit after the rising edge that starts cycle t.
module tb_sprite_access_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_req;
  logic [9:0] H_in, V_in;
  logic       pix_ack, pix_overrun;
  logic       active_finder_position;
  logic [9:0] H_pos_out, V_pos_out;
  logic       active_function_processor;
  logic [1:0] function_selector;
  logic [5:0] function_level_sprit, function_id_sprit, function_input01, function_input02;
  logic [9:0] function_col, function_row;
  logic       active_high_four, function_sp_colision_out;
  logic       colision_valid, colision_hit, timeout_err, bad_cmd;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pix    = 0;
  int n_func   = 0;
  int n_ack    = 0;
  int n_colv   = 0;
  int n_both   = 0;
  int base_a, base_b;

  sprite_access_scheduler_if cmd_bus ();

  sprite_access_scheduler #(.FIFO_DEPTH(4), .FUNC_WAIT(4), .PIX_TIMEOUT(16)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .pix_req                   (pix_req),
    .H_in                      (H_in),
    .V_in                      (V_in),
    .pix_ack                   (pix_ack),
    .pix_overrun               (pix_overrun),
    .cmd                       (cmd_bus),
    .active_finder_position    (active_finder_position),
    .H_pos_out                 (H_pos_out),
    .V_pos_out                 (V_pos_out),
    .active_function_processor (active_function_processor),
    .function_selector         (function_selector),
    .function_level_sprit      (function_level_sprit),
    .function_id_sprit         (function_id_sprit),
    .function_input01          (function_input01),
    .function_input02          (function_input02),
    .function_col              (function_col),
    .function_row              (function_row),
    .active_high_four          (active_high_four),
    .function_sp_colision_out  (function_sp_colision_out),
    .colision_valid            (colision_valid),
    .colision_hit              (colision_hit),
    .timeout_err               (timeout_err),
    .bad_cmd                   (bad_cmd),
    .fifo_count                (fifo_count)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (active_finder_position)    n_pix++;
    if (active_function_processor) n_func++;
    if (pix_ack)                   n_ack++;
    if (colision_valid)            n_colv++;
    if (active_finder_position && active_function_processor) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the command channel; command k carries fields derived from k.
  task automatic drive_cmd(input logic valid, input logic [1:0] sel, input int k);
    cmd_bus.cmd_valid    = valid;
    cmd_bus.cmd_selector = sel;
    cmd_bus.cmd_level    = 6'(k + 1);
    cmd_bus.cmd_id       = 6'(k + 10);
    cmd_bus.cmd_in01     = 6'(k + 20);
    cmd_bus.cmd_in02     = 6'(k + 30);
    cmd_bus.cmd_col      = 10'(100 + k);
    cmd_bus.cmd_row      = 10'(200 + k);
  endtask

  initial begin
    rst = 1'b0;
    pix_req = 1'b0; H_in = '0; V_in = '0;
    active_high_four = 1'b0; function_sp_colision_out = 1'b0;
    drive_cmd(1'b0, 2'b00, 0);
    tick(); tick();

    // Reset state
    check("rst_cmd_ready", 32'(cmd_bus.cmd_ready), 1);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_pix_start", 32'(active_finder_position), 0);
    check("rst_func_start", 32'(active_function_processor), 0);
    check("rst_flags", 32'({timeout_err, bad_cmd, pix_overrun, colision_valid, pix_ack}), 0);
    rst = 1'b1;
    tick();

    // Single pixel lookup, finder strobes 3 cycles after start
    for (int t = 0; t < 8; t++) begin
      pix_req = (t == 0); H_in = 10'd100; V_in = 10'd50;
      active_high_four = (t == 5);
      if (t == 1) check("pix_start_early", 32'(active_finder_position), 0);
      if (t == 2) begin
        check("pix_start", 32'(active_finder_position), 1);
        check("pix_h", 32'(H_pos_out), 100);
        check("pix_v", 32'(V_pos_out), 50);
      end
      if (t == 6) check("pix_ack", 32'(pix_ack), 1);
      if (t == 7) check("pix_ack_once", 32'(pix_ack), 0);
      tick();
    end
    active_high_four = 1'b0; pix_req = 1'b0;

    // Commands 00, 01, 10 back-to-back; collision input high mid-wait of the 10
    for (int t = 0; t < 22; t++) begin
      drive_cmd(t < 3, 2'(t), t);
      function_sp_colision_out = (t == 16);
      if (t > 0) begin
        check($sformatf("cmd_start_c%0d", t), 32'(active_function_processor),
              32'(t == 2 || t == 8 || t == 14));
        check($sformatf("colv_c%0d", t), 32'(colision_valid), 32'(t == 18));
      end
      if (t == 2 || t == 8 || t == 14) begin
        check($sformatf("cmd_sel_c%0d", t), 32'(function_selector), (t - 2) / 6);
        check($sformatf("cmd_level_c%0d", t), 32'(function_level_sprit), (t - 2) / 6 + 1);
        check($sformatf("cmd_col_c%0d", t), 32'(function_col), 100 + (t - 2) / 6);
      end
      if (t == 18) check("col_hit_high", 32'(colision_hit), 1);
      tick();
    end
    function_sp_colision_out = 1'b0;

    // Collision command with the finder flag low throughout
    for (int t = 0; t < 9; t++) begin
      drive_cmd(t == 0, 2'b10, 5);
      if (t == 6) begin
        check("col_valid_low", 32'(colision_valid), 1);
        check("col_hit_low", 32'(colision_hit), 0);
      end
      tick();
    end

    // Fill FIFO during a long pixel wait; a pending pixel must yield to one command
    for (int t = 0; t < 43; t++) begin
      pix_req = (t == 0 || t == 8);
      H_in = (t == 0) ? 10'd300 : 10'd400;
      V_in = (t == 0) ? 10'd301 : 10'd401;
      drive_cmd(t >= 3 && t <= 6, 2'b00, t);
      active_high_four = (t == 10 || t == 20);
      if (t == 7) begin
        check("full_count", 32'(fifo_count), 4);
        check("full_ready", 32'(cmd_bus.cmd_ready), 0);
      end
      if (t == 11) check("full_pix_ack", 32'(pix_ack), 1);
      if (t == 12) begin
        check("full_cmd_first", 32'(active_function_processor), 1);
        check("full_cmd_level", 32'(function_level_sprit), 4);
      end
      if (t == 13) check("full_ready_again", 32'(cmd_bus.cmd_ready), 1);
      if (t == 18) begin
        check("full_pix_next", 32'(active_finder_position), 1);
        check("full_pix_h", 32'(H_pos_out), 400);
      end
      if (t == 42) check("drain_count", 32'(fifo_count), 0);
      tick();
    end
    pix_req = 1'b0; active_high_four = 1'b0;

    // Timeout with no strobe, plus two requests while pending
    for (int t = 0; t < 25; t++) begin
      pix_req = (t == 0 || t == 5 || t == 7);
      H_in = (t == 7) ? 10'd33 : ((t == 5) ? 10'd11 : 10'd1);
      V_in = (t == 7) ? 10'd44 : ((t == 5) ? 10'd22 : 10'd2);
      active_high_four = (t == 22);
      if (t == 0) base_a = n_ack;
      if (t == 6) check("overrun_clear", 32'(pix_overrun), 0);
      if (t == 8) check("overrun_set", 32'(pix_overrun), 1);
      if (t == 18) check("timeout_early", 32'(timeout_err), 0);
      if (t == 19) begin
        check("timeout_set", 32'(timeout_err), 1);
        check("timeout_no_ack", n_ack, base_a);
      end
      if (t == 20) begin
        check("overrun_issue", 32'(active_finder_position), 1);
        check("overrun_h", 32'(H_pos_out), 33);
        check("overrun_v", 32'(V_pos_out), 44);
      end
      if (t == 23) check("overrun_ack", 32'(pix_ack), 1);
      tick();
    end
    pix_req = 1'b0; active_high_four = 1'b0;

    // Illegal selector: no start pulse, bad_cmd set
    for (int t = 0; t < 7; t++) begin
      drive_cmd(t == 0, 2'b11, 9);
      if (t == 0) base_a = n_func;
      if (t == 2) check("bad_early", 32'(bad_cmd), 0);
      if (t == 3) check("bad_set", 32'(bad_cmd), 1);
      if (t == 6) check("bad_no_start", n_func, base_a);
      tick();
    end

    // Reset asserted during CMD_WAIT
    drive_cmd(1'b1, 2'b10, 7);
    function_sp_colision_out = 1'b1;
    tick();
    drive_cmd(1'b0, 2'b10, 7);
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    check("mid_rst_sel", 32'(function_selector), 0);
    check("mid_rst_level", 32'(function_level_sprit), 0);
    check("mid_rst_count", 32'(fifo_count), 0);
    check("mid_rst_ready", 32'(cmd_bus.cmd_ready), 1);
    check("mid_rst_flags", 32'({timeout_err, bad_cmd, pix_overrun, colision_hit}), 0);
    check("mid_rst_hpos", 32'(H_pos_out), 0);
    base_a = n_colv;
    base_b = n_func;
    function_sp_colision_out = 1'b0;
    tick(); tick();
    rst = 1'b1;
    for (int t = 0; t < 8; t++) tick();
    check("mid_rst_no_colv", n_colv, base_a);
    check("mid_rst_no_start", n_func, base_b);
    check("start_overlap", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
